// File: rtl/top_pkg.sv
// Shared definitions for the pattern-count engine: FSM states, memory map, window-match helpers.
package top_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOADP = 3'd1,
    SCAN  = 3'd2,
    WR0   = 3'd3,
    WR1   = 3'd4,
    WR2   = 3'd5,
    DONE  = 3'd6
  } state_e;

  localparam logic [7:0] PAT_ADDR  = 8'd32;
  localparam logic [7:0] CTB_ADDR  = 8'd33;
  localparam logic [7:0] CTO_ADDR  = 8'd34;
  localparam logic [7:0] CTS_ADDR  = 8'd35;
  localparam int         MSG_BYTES = 32;

  // Matches among b[4:0], b[5:1], b[6:2], b[7:3].
  function automatic logic [2:0] byte_hits(input logic [7:0] b, input logic [4:0] p);
    logic [2:0] n;
    n = '0;
    for (int k = 0; k < 4; k++) begin
      if (b[k +: 5] == p) n = n + 3'd1;
    end
    return n;
  endfunction

  // Windows straddling prev/cur: bits [11:7]..[8:4] of {prev,cur}.
  function automatic logic [2:0] cross_hits(input logic [7:0] prev, input logic [7:0] cur,
                                            input logic [4:0] p);
    logic [15:0] w;
    logic [2:0]  n;
    w = {prev, cur};
    n = '0;
    for (int k = 4; k < 8; k++) begin
      if (w[k +: 5] == p) n = n + 3'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/data_mem.sv
// 256x8 data memory: combinational read, single synchronous write port, no reset on contents.
module data_mem (
  input  logic       clk_i,
  input  logic       we_i,
  input  logic [7:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [7:0] raddr_i,
  output logic [7:0] rdata_o
);

  logic [7:0] core [0:255];

  always_ff @(posedge clk_i) begin
    if (we_i) core[waddr_i] <= wdata_i;
  end

  assign rdata_o = core[raddr_i];

endmodule

// File: rtl/top_level.sv
// Scans the 32-byte message for a 5-bit pattern and writes in-byte, per-byte and bit-string
// match counts back to memory; done is high 37 clocks after the start-sampling edge.
module top_level
  import top_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic start,
  output logic done
);

  state_e     state_q, state_d;
  logic [4:0] idx_q, idx_d;
  logic [4:0] pat_q, pat_d;
  logic [7:0] prev_q, prev_d;
  logic [7:0] ctb_q, ctb_d;
  logic [7:0] cto_q, cto_d;
  logic [7:0] cts_q, cts_d;
  logic       done_q, done_d;

  logic       mem_we;
  logic [7:0] mem_waddr, mem_wdata, mem_raddr, mem_rdata;
  logic [2:0] in_hits, x_hits;

  data_mem dm1 (
    .clk_i   (clock),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .raddr_i (mem_raddr),
    .rdata_o (mem_rdata)
  );

  assign in_hits = byte_hits(mem_rdata, pat_q);
  // Byte 0 has no predecessor, so no crossing windows there.
  assign x_hits  = (idx_q == 5'd0) ? 3'd0 : cross_hits(prev_q, mem_rdata, pat_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pat_q   <= '0;
      prev_q  <= '0;
      ctb_q   <= '0;
      cto_q   <= '0;
      cts_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
      prev_q  <= prev_d;
      ctb_q   <= ctb_d;
      cto_q   <= cto_d;
      cts_q   <= cts_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pat_d     = pat_q;
    prev_d    = prev_q;
    ctb_d     = ctb_q;
    cto_d     = cto_q;
    cts_d     = cts_q;
    done_d    = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = CTB_ADDR;
    mem_wdata = ctb_q;
    mem_raddr = {3'b000, idx_q};

    case (state_q)
      IDLE: begin
        if (start) state_d = LOADP;
      end
      LOADP: begin
        mem_raddr = PAT_ADDR;
        pat_d     = mem_rdata[7:3];
        idx_d     = '0;
        prev_d    = '0;
        ctb_d     = '0;
        cto_d     = '0;
        cts_d     = '0;
        state_d   = SCAN;
      end
      SCAN: begin
        ctb_d  = ctb_q + 8'(in_hits);
        cto_d  = cto_q + 8'(in_hits != 3'd0);
        cts_d  = cts_q + 8'(in_hits) + 8'(x_hits);
        prev_d = mem_rdata;
        idx_d  = idx_q + 5'd1;
        if (idx_q == 5'(MSG_BYTES - 1)) state_d = WR0;
      end
      WR0: begin
        mem_we    = 1'b1;
        mem_waddr = CTB_ADDR;
        mem_wdata = ctb_q;
        state_d   = WR1;
      end
      WR1: begin
        mem_we    = 1'b1;
        mem_waddr = CTO_ADDR;
        mem_wdata = cto_q;
        state_d   = WR2;
      end
      WR2: begin
        mem_we    = 1'b1;
        mem_waddr = CTS_ADDR;
        mem_wdata = cts_q;
        state_d   = DONE;
      end
      DONE: begin
        // done is registered, so it follows one cycle behind entry to DONE.
        if (start) state_d = LOADP;
        else       done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign done = done_q;

endmodule

// File: tb/tb_top_level.sv
// Self-checking bench for top_level: directed memory patterns plus randomized messages vs a bit-string model.
module tb_top_level;

  logic clock = 1'b0;
  logic reset;
  logic start;
  logic done;

  always #5 clock = ~clock;

  top_level dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .done  (done)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] msg [32];
  logic [4:0] pat;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic load_mem;
    for (int i = 0; i < 32; i++) dut.dm1.core[i] = msg[i];
    dut.dm1.core[32] = {pat, 3'($urandom_range(0, 7))};
  endtask

  task automatic fill_msg(input logic [7:0] v);
    for (int i = 0; i < 32; i++) msg[i] = v;
  endtask

  // Treats the message as one 256-bit string; byte counts use shifted per-byte views.
  function automatic void model(output int ctb, output int cto, output int cts);
    logic [255:0] s;
    logic [7:0]   sh;
    int           hits;
    for (int i = 0; i < 32; i++) s[255 - 8*i -: 8] = msg[i];
    cts = 0;
    for (int pos = 0; pos <= 251; pos++) if (s[255 - pos -: 5] == pat) cts++;
    ctb = 0;
    cto = 0;
    for (int i = 0; i < 32; i++) begin
      hits = 0;
      for (int k = 0; k < 4; k++) begin
        sh = msg[i] >> k;
        if (sh[4:0] == pat) hits++;
      end
      ctb += hits;
      if (hits > 0) cto++;
    end
  endfunction

  // Pulses start for one edge and counts edges until done rises (-1 on timeout).
  task automatic run_engine(output int lat, output logic d0);
    start = 1'b1;
    tick();
    d0    = done;
    start = 1'b0;
    lat   = -1;
    for (int n = 1; n <= 200; n++) begin
      tick();
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic read_res(output int a, output int b, output int c);
    a = int'(dut.dm1.core[33]);
    b = int'(dut.dm1.core[34]);
    c = int'(dut.dm1.core[35]);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    tick();
    tick();
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL reset_done: got %b want 0", done);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_directed;
    int exp_t [5][3] = '{'{128, 32, 252}, '{64, 32, 126}, '{0, 0, 0}, '{128, 32, 252}, '{0, 0, 1}};
    int lat, a, b, c;
    logic d0;
    for (int cs = 0; cs < 5; cs++) begin
      case (cs)
        0: begin fill_msg(8'h00); pat = 5'b00000; end
        1: begin fill_msg(8'h55); pat = 5'b10101; end
        2: begin fill_msg(8'hFF); pat = 5'b00000; end
        3: pat = 5'b11111;
        default: begin fill_msg(8'h00); msg[0] = 8'h03; msg[1] = 8'hE0; pat = 5'b11111; end
      endcase
      load_mem();
      run_engine(lat, d0);
      read_res(a, b, c);
      total += 5;
      if (d0 !== 1'b0) begin bad++; $display("FAIL dir%0d_done_on_start: got %b want 0", cs, d0); end
      if (lat !== 37)  begin bad++; $display("FAIL dir%0d_latency: got %0d want 37", cs, lat); end
      if (a !== exp_t[cs][0]) begin bad++; $display("FAIL dir%0d_ctb: got %0d want %0d", cs, a, exp_t[cs][0]); end
      if (b !== exp_t[cs][1]) begin bad++; $display("FAIL dir%0d_cto: got %0d want %0d", cs, b, exp_t[cs][1]); end
      if (c !== exp_t[cs][2]) begin bad++; $display("FAIL dir%0d_cts: got %0d want %0d", cs, c, exp_t[cs][2]); end
    end
    for (int n = 0; n < 5; n++) tick();
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL done_held: got %b want 1", done); end
  endtask

  task automatic test_random;
    int lat, a, b, c, ea, eb, ec, diffs;
    logic d0;
    logic [7:0] src;
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 32; i++) begin
        msg[i] = 8'($urandom);
        if (it >= 6) msg[i] = msg[i] & 8'hC3;
      end
      src = msg[$urandom_range(0, 31)];
      if (it % 2 == 0) pat = 5'(src >> $urandom_range(0, 3));
      else             pat = 5'($urandom);
      load_mem();
      model(ea, eb, ec);
      run_engine(lat, d0);
      read_res(a, b, c);
      total += 4;
      if (lat !== 37) begin bad++; $display("FAIL rnd%0d_latency: got %0d want 37", it, lat); end
      if (a !== ea) begin bad++; $display("FAIL rnd%0d_ctb: got %0d want %0d", it, a, ea); end
      if (b !== eb) begin bad++; $display("FAIL rnd%0d_cto: got %0d want %0d", it, b, eb); end
      if (c !== ec) begin bad++; $display("FAIL rnd%0d_cts: got %0d want %0d", it, c, ec); end
    end
    diffs = 0;
    for (int i = 0; i < 32; i++) if (dut.dm1.core[i] !== msg[i]) diffs++;
    if (dut.dm1.core[32][7:3] !== pat) diffs++;
    total++;
    if (diffs != 0) begin bad++; $display("FAIL input_region_intact: got %0d changed bytes want 0", diffs); end
  endtask

  task automatic test_start_ignored;
    int lat, a, b, c, ea, eb, ec;
    for (int i = 0; i < 32; i++) msg[i] = 8'($urandom);
    pat = 5'(msg[7] >> 2);
    load_mem();
    model(ea, eb, ec);
    start = 1'b1;
    tick();
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      start = (n == 5 || n == 20 || n == 35) ? 1'b1 : 1'b0;
      tick();
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
    start = 1'b0;
    read_res(a, b, c);
    total += 4;
    if (lat !== 37) begin bad++; $display("FAIL busy_start_latency: got %0d want 37", lat); end
    if (a !== ea) begin bad++; $display("FAIL busy_start_ctb: got %0d want %0d", a, ea); end
    if (b !== eb) begin bad++; $display("FAIL busy_start_cto: got %0d want %0d", b, eb); end
    if (c !== ec) begin bad++; $display("FAIL busy_start_cts: got %0d want %0d", c, ec); end
  endtask

  task automatic test_reset_midrun;
    int lat, a, b, c, ea, eb, ec, seen;
    logic d0;
    fill_msg(8'h00);
    pat = 5'b00000;
    load_mem();
    run_engine(lat, d0);
    for (int i = 0; i < 32; i++) msg[i] = 8'($urandom) | 8'h01;
    pat = 5'b11011;
    load_mem();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 10; n++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    seen = 0;
    for (int n = 0; n < 45; n++) begin
      tick();
      if (done !== 1'b0) seen++;
    end
    read_res(a, b, c);
    total += 4;
    if (seen != 0) begin bad++; $display("FAIL abort_done: got %0d high cycles want 0", seen); end
    if (a !== 128) begin bad++; $display("FAIL abort_ctb_kept: got %0d want 128", a); end
    if (b !== 32)  begin bad++; $display("FAIL abort_cto_kept: got %0d want 32", b); end
    if (c !== 252) begin bad++; $display("FAIL abort_cts_kept: got %0d want 252", c); end
    model(ea, eb, ec);
    run_engine(lat, d0);
    read_res(a, b, c);
    total += 4;
    if (lat !== 37) begin bad++; $display("FAIL post_abort_latency: got %0d want 37", lat); end
    if (a !== ea) begin bad++; $display("FAIL post_abort_ctb: got %0d want %0d", a, ea); end
    if (b !== eb) begin bad++; $display("FAIL post_abort_cto: got %0d want %0d", b, eb); end
    if (c !== ec) begin bad++; $display("FAIL post_abort_cts: got %0d want %0d", c, ec); end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
